// File: rtl/pe_sequencer.sv
// Phase sequencer for the complex-data PE: LOAD -> (COMPUTE -> TRANSMIT -> SHIFT) x iter -> OUTPUT,
// with runtime phase lengths, backpressure, zero-length phase skipping and abort.
module pe_sequencer #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ITER_W    = 8,
    parameter int unsigned IM_ADDR_W = 8,
    parameter int unsigned DEF_LOAD  = 16,
    parameter int unsigned DEF_INST  = 32,
    parameter int unsigned DEF_TX    = 4,
    parameter int unsigned DEF_SHIFT = 16,
    parameter int unsigned DEF_OUT   = 4,
    parameter int unsigned DEF_ITER  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_v,
    input  logic [CNT_W-1:0]     cfg_load_num,
    input  logic [CNT_W-1:0]     cfg_inst_num,
    input  logic [CNT_W-1:0]     cfg_tx_num,
    input  logic [CNT_W-1:0]     cfg_shift_num,
    input  logic [CNT_W-1:0]     cfg_out_num,
    input  logic [ITER_W-1:0]    cfg_iter_num,
    input  logic                 din_pe_v,
    input  logic                 tx_rdy,
    input  logic                 out_rdy,
    input  logic                 abort,
    output logic                 start,
    output logic                 load_v,
    output logic                 cmpt_v,
    output logic                 tx_v,
    output logic                 shift_v,
    output logic                 output_v,
    output logic [IM_ADDR_W-1:0] inst_addr,
    output logic [ITER_W-1:0]    iter_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CMPT  = 3'd2,
        S_TX    = 3'd3,
        S_SHIFT = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]     load_num, inst_num, tx_num, shift_num, out_num;
    logic [ITER_W-1:0]    iter_num;
    logic [CNT_W-1:0]     beat, beat_nxt, cur_num;
    logic [ITER_W-1:0]    iter_nxt;
    logic [IM_ADDR_W-1:0] addr_nxt;
    logic                 done_nxt;
    logic                 beat_acc, phase_last, last_iter;

    // Strobes are a pure decode of the state register.
    assign start    = (state == S_IDLE);
    assign load_v   = (state == S_LOAD);
    assign cmpt_v   = (state == S_CMPT);
    assign tx_v     = (state == S_TX);
    assign shift_v  = (state == S_SHIFT);
    assign output_v = (state == S_OUT);
    assign busy     = (state != S_IDLE);

    // Length of the current phase and whether this cycle carries an accepted beat.
    always_comb begin
        cur_num  = '0;
        beat_acc = 1'b0;
        unique case (state)
            S_LOAD:  begin cur_num = load_num;  beat_acc = 1'b1;    end
            S_CMPT:  begin cur_num = inst_num;  beat_acc = 1'b1;    end
            S_TX:    begin cur_num = tx_num;    beat_acc = tx_rdy;  end
            S_SHIFT: begin cur_num = shift_num; beat_acc = 1'b1;    end
            S_OUT:   begin cur_num = out_num;   beat_acc = out_rdy; end
            default: begin cur_num = '0;        beat_acc = 1'b0;    end
        endcase
    end

    assign phase_last = beat_acc && (beat == cur_num - CNT_W'(1));
    assign last_iter  = (iter_cnt == iter_num - ITER_W'(1));

    // Next-state, counter and done decision; abort outranks phase end, which outranks stall.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        iter_nxt  = iter_cnt;
        addr_nxt  = '0;
        done_nxt  = 1'b0;
        if (state == S_IDLE) begin
            if (din_pe_v && !abort) begin
                beat_nxt  = '0;
                iter_nxt  = '0;
                state_nxt = (load_num != '0) ? S_LOAD : S_CMPT;
            end
        end else if (abort) begin
            state_nxt = S_IDLE;
            beat_nxt  = '0;
            iter_nxt  = '0;
        end else if (phase_last) begin
            beat_nxt = '0;
            unique case (state)
                S_LOAD: state_nxt = S_CMPT;
                S_CMPT: begin
                    if (last_iter) begin
                        if (out_num != '0) begin
                            state_nxt = S_OUT;
                        end else begin
                            state_nxt = S_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else if (tx_num != '0) begin
                        state_nxt = S_TX;
                    end else if (shift_num != '0) begin
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_CMPT;
                        iter_nxt  = iter_cnt + ITER_W'(1);
                    end
                end
                S_TX: begin
                    if (shift_num != '0) begin
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_CMPT;
                        iter_nxt  = iter_cnt + ITER_W'(1);
                    end
                end
                S_SHIFT: begin
                    state_nxt = S_CMPT;
                    iter_nxt  = iter_cnt + ITER_W'(1);
                end
                S_OUT: begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (beat_acc) begin
            beat_nxt = beat + CNT_W'(1);
            if (state == S_CMPT) begin
                addr_nxt = inst_addr + IM_ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= '0;
            iter_cnt  <= '0;
            inst_addr <= '0;
            done      <= 1'b0;
        end else begin
            beat      <= beat_nxt;
            iter_cnt  <= iter_nxt;
            inst_addr <= addr_nxt;
            done      <= done_nxt;
        end
    end

    // Config is only writable while idle, so it stays constant for the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_num  <= CNT_W'(DEF_LOAD);
            inst_num  <= CNT_W'(DEF_INST);
            tx_num    <= CNT_W'(DEF_TX);
            shift_num <= CNT_W'(DEF_SHIFT);
            out_num   <= CNT_W'(DEF_OUT);
            iter_num  <= ITER_W'(DEF_ITER);
            cfg_err   <= 1'b0;
        end else if (cfg_v && (state == S_IDLE)) begin
            if ((cfg_inst_num != '0) && (cfg_iter_num != '0)) begin
                load_num  <= cfg_load_num;
                inst_num  <= cfg_inst_num;
                tx_num    <= cfg_tx_num;
                shift_num <= cfg_shift_num;
                out_num   <= cfg_out_num;
                iter_num  <= cfg_iter_num;
                cfg_err   <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Parametrised, runtime-configurable phase sequencer for the complex-data PE.
- Runs the LOAD -> (COMPUTE -> TRANSMIT -> SHIFT) x iterations -> OUTPUT schedule with per-phase counts set at run time.
- Adds backpressure on TRANSMIT/OUTPUT, zero-length phase skipping, abort, and a done pulse.
- Drives the instruction-ROM address/iteration inputs and the DMEM/forwarding valid strobes of the PE datapath.

Parameters:
CNT_W, 8, width of every per-phase cycle count
ITER_W, 8, width of iteration count and iter_cnt
IM_ADDR_W, 8, width of inst_addr
DEF_LOAD, 16, reset value of load count
DEF_INST, 32, reset value of compute count
DEF_TX, 4, reset value of transmit count
DEF_SHIFT, 16, reset value of shift count
DEF_OUT, 4, reset value of output count
DEF_ITER, 4, reset value of iteration count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_v  in  1  config write strobe; accepted only in IDLE
cfg_load_num, cfg_inst_num, cfg_tx_num, cfg_shift_num, cfg_out_num  in  CNT_W each  phase lengths in beats
cfg_iter_num  in  ITER_W  iterations per run
din_pe_v  in  1  run start (first load beat valid)
tx_rdy  in  1  downstream accepts transmit beat
out_rdy  in  1  downstream accepts output beat
abort  in  1  synchronous run abort
start, load_v, cmpt_v, tx_v, shift_v, output_v  out  1 each  one-hot phase strobes
inst_addr  out  IM_ADDR_W  instruction address within COMPUTE
iter_cnt  out  ITER_W  current iteration index
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at run completion
cfg_err  out  1  sticky: last cfg_v rejected

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; config registers=DEF_* values; all counters, inst_addr, iter_cnt, done, cfg_err=0. start=1 (IDLE decode); all other strobes=0.
- Strobes are a direct decode of the state register. A strobe is high in every cycle spent in its state, including stall cycles. No extra delay stage.
- Config: cfg_v in IDLE with cfg_inst_num!=0 and cfg_iter_num!=0 loads all six registers and clears cfg_err. If either is 0, config is unchanged and cfg_err=1. cfg_v outside IDLE is ignored with no flag.
- IDLE: din_pe_v=1 -> first non-zero phase among LOAD, COMPUTE. iter_cnt and beat counter are cleared on this transition.
- A beat counter counts accepted beats in the current phase; a phase ends after the beat where count==N-1.
  - LOAD, COMPUTE, SHIFT: one beat per cycle.
  - TRANSMIT: a beat is accepted only when tx_rdy=1.
  - OUTPUT: a beat is accepted only when out_rdy=1.
- After COMPUTE:
  - if iter_cnt==iter_num-1 -> OUTPUT;
  - else -> TRANSMIT. If tx_num=0 -> SHIFT. If shift_num=0 as well -> COMPUTE, with iter_cnt incremented.
- TRANSMIT end -> SHIFT, or COMPUTE if shift_num=0.
- iter_cnt increments exactly once per non-final iteration, on entry to the next COMPUTE.
- OUTPUT end -> IDLE with done=1 for one cycle. If out_num=0, the final COMPUTE goes directly to IDLE and asserts done.
- inst_addr:
  - 0 on COMPUTE entry;
  - +1 each COMPUTE cycle;
  - wraps modulo 2^IM_ADDR_W if inst_num > 2^IM_ADDR_W;
  - held at 0 in all other states.
- Beat counters are CNT_W wide. A count of 2^CNT_W-1 is legal. Config values are sampled at run start and constant during the run.
- abort=1 in any non-IDLE state:
  - next state IDLE; counters, inst_addr and iter_cnt cleared; no done pulse.
  - Priority: abort > phase end > stall.
  - abort in IDLE has no effect. abort with din_pe_v in the same IDLE cycle: abort wins and the run does not start.
- din_pe_v outside IDLE is ignored.
- rst_n deasserted mid-run: immediate IDLE. Config returns to DEF_* values.

Test Plan:
- Defaults, din_pe_v pulse, tx_rdy=out_rdy=1 -> load_v 16 cycles; 4x cmpt_v 32 cycles with inst_addr 0..31; 3x(tx_v 4, shift_v 16); output_v 4; done pulse; total 16+128+60+4=208 busy cycles.
- Config load=2 inst=3 tx=1 shift=1 out=1 iter=2; tx_rdy low for 5 cycles during TRANSMIT -> tx_v held 6 cycles, shift_v follows only after the accepted beat, iter_cnt 0->1 on second COMPUTE entry.
- Config tx=0, shift=0, out=0, iter=3, inst=2 -> cmpt_v 6 consecutive cycles, iter_cnt 0,1,2; done in the cycle after last cmpt_v; tx_v/shift_v/output_v never asserted.
- cfg_v with cfg_iter_num=0 -> cfg_err=1 and previous config retained; a subsequent valid cfg_v -> cfg_err=0.
- abort on 10th COMPUTE cycle of iteration 1 -> next cycle IDLE, start=1, iter_cnt=0, inst_addr=0, no done; the next din_pe_v runs a full schedule.
- rst_n low for half a cycle mid-TRANSMIT -> outputs clear asynchronously; config reads back DEF_* behaviour on the next run.
